// File: rtl/onchip_mem_copy_master_if.sv
`default_nettype none
// Avalon-MM port of a single-port on-chip RAM, as seen by a word-copy master.
interface onchip_mem_copy_master_if #(
   parameter int ADDR_W = 14
);
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_clken;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic [31:0]       mem_readdata;

   modport master (
      output mem_address, mem_byteenable, mem_chipselect, mem_clken,
             mem_write, mem_writedata,
      input  mem_readdata
   );

   modport slave (
      input  mem_address, mem_byteenable, mem_chipselect, mem_clken,
             mem_write, mem_writedata,
      output mem_readdata
   );
endinterface
`default_nettype wire

// File: rtl/onchip_mem_copy_master.sv
`default_nettype none
// onchip_mem_copy_master: forward word-by-word block copy (read then write)
// inside a single-port on-chip RAM, with range check and pause support.
module onchip_mem_copy_master #(
   parameter int ADDR_W       = 14,
   parameter int DEPTH        = 12000,
   parameter int READ_LATENCY = 1
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              start,
   input  wire logic [ADDR_W-1:0] src,
   input  wire logic [ADDR_W-1:0] dst,
   input  wire logic [ADDR_W-1:0] len,
   input  wire logic              pause,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   onchip_mem_copy_master_if.master mem
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RD    = 3'd1;
   localparam logic [2:0] RWAIT = 3'd2;
   localparam logic [2:0] WR    = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [1:0]        LAT_INIT = 2'(READ_LATENCY - 1);
   localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] index;
   logic [1:0]        lat_cnt;
   logic [31:0]       rdata;
   logic              err_q;

   logic [ADDR_W:0]   src_end;
   logic [ADDR_W:0]   dst_end;
   logic              reject;

   // One extra bit so the end-of-range sums cannot wrap past zero.
   assign src_end = {1'b0, src} + {1'b0, len};
   assign dst_end = {1'b0, dst} + {1'b0, len};
   assign reject  = (len == '0) || (src_end > DEPTH_W) || (dst_end > DEPTH_W);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         index   <= '0;
         lat_cnt <= '0;
         rdata   <= '0;
         err_q   <= 1'b0;
      end else if (state == IDLE) begin
         // Pause never blocks acceptance of a new request.
         if (start) begin
            src_q <= src;
            dst_q <= dst;
            len_q <= len;
            index <= '0;
            err_q <= reject;
            state <= reject ? DONE : RD;
         end
      end else if (!pause) begin
         case (state)
            RD: begin
               lat_cnt <= LAT_INIT;
               state   <= RWAIT;
            end
            RWAIT: begin
               if (lat_cnt == 2'd0) begin
                  rdata <= mem.mem_readdata;
                  state <= WR;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            WR: begin
               if (index == len_q - ONE) begin
                  state <= DONE;
               end else begin
                  index <= index + ONE;
                  state <= RD;
               end
            end
            DONE: begin
               err_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus outputs decode from held state, so they freeze naturally under pause.
   always_comb begin
      mem.mem_chipselect = 1'b0;
      mem.mem_write      = 1'b0;
      mem.mem_address    = '0;
      mem.mem_byteenable = 4'h0;
      mem.mem_writedata  = '0;
      case (state)
         RD: begin
            mem.mem_chipselect = 1'b1;
            mem.mem_address    = src_q + index;
            mem.mem_byteenable = 4'hF;
         end
         WR: begin
            mem.mem_chipselect = 1'b1;
            mem.mem_write      = 1'b1;
            mem.mem_address    = dst_q + index;
            mem.mem_byteenable = 4'hF;
            mem.mem_writedata  = rdata;
         end
         default: ;
      endcase
   end

   assign mem.mem_clken = ~pause;
   assign busy          = (state == RD) || (state == RWAIT) || (state == WR);
   assign done          = (state == DONE);
   assign err           = (state == DONE) && err_q;
endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_copy_master.sv
`default_nettype none
// Randomised self-checking bench for onchip_mem_copy_master against a RAM
// model and an array-based reference of the copy semantics.
module tb_onchip_mem_copy_master;
   localparam int ADDR_W = 14;
   localparam int DEPTH  = 12000;
   localparam int RL     = 1;
   localparam int NWORDS = 16384;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              pause;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [ADDR_W-1:0] len;
   logic              busy;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;
   int bad_bus  = 0;

   onchip_mem_copy_master_if #(.ADDR_W(ADDR_W)) bus ();

   onchip_mem_copy_master #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
      .pause(pause), .busy(busy), .done(done), .err(err), .mem(bus.master)
   );

   always #5 clk = ~clk;

   // RAM model: clock-enabled, registered read path of RL stages.
   logic [31:0] ram     [0:NWORDS-1];
   logic [31:0] rd_pipe [0:RL-1];
   int          last_rd;

   always @(posedge clk) begin
      if (bus.mem_clken) begin
         if (bus.mem_chipselect && bus.mem_write && bus.mem_byteenable == 4'hF)
            ram[bus.mem_address] <= bus.mem_writedata;
         if (bus.mem_chipselect && !bus.mem_write) begin
            rd_pipe[0] <= ram[bus.mem_address];
            last_rd    <= int'(bus.mem_address);
         end
         for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end
   assign bus.mem_readdata = rd_pipe[RL-1];

   always @(posedge clk) begin
      if (!reset) begin
         if (bus.mem_write && !bus.mem_chipselect) bad_bus <= bad_bus + 1;
         if (bus.mem_chipselect && bus.mem_byteenable != 4'hF) bad_bus <= bad_bus + 1;
         if (!bus.mem_chipselect && bus.mem_byteenable != 4'h0) bad_bus <= bad_bus + 1;
      end
   end

   // Reference memory image and copy semantics.
   logic [31:0] mdl [0:NWORDS-1];

   task automatic preload(input int a, input logic [31:0] v);
      ram[a] <= v;
      mdl[a]  = v;
   endtask

   function automatic bit expect_reject(input int s, input int d, input int l);
      return (l == 0) || (s + l > DEPTH) || (d + l > DEPTH);
   endfunction

   task automatic model_copy(input int s, input int d, input int l);
      for (int i = 0; i < l; i++) mdl[d+i] = mdl[s+i];
   endtask

   task automatic run_copy(input int s, input int d, input int l,
                           input int pause_at, input int pause_len, input int spur_at,
                           output int done_cyc, output logic err_o,
                           output int cs_cnt, output int busy_cnt, output int clken_low);
      int cyc;
      done_cyc = -1; err_o = 1'bx; cs_cnt = 0; busy_cnt = 0; clken_low = 0;
      @(posedge clk); #1;
      src = ADDR_W'(s); dst = ADDR_W'(d); len = ADDR_W'(l); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc <= 300) begin
         if (cyc == pause_at) pause = 1'b1;
         if (cyc == pause_at + pause_len) pause = 1'b0;
         if (cyc == spur_at) begin
            start = 1'b1;
            src = ADDR_W'($urandom_range(0, 50));
            dst = ADDR_W'($urandom_range(0, 50));
            len = ADDR_W'($urandom_range(1, 4));
         end else begin
            start = 1'b0;
         end
         #1;
         if (bus.mem_chipselect) cs_cnt++;
         if (busy) busy_cnt++;
         if (!bus.mem_clken) clken_low++;
         if (done) begin
            done_cyc = cyc;
            err_o    = err;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      pause = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; pause = 1'b0; src = '0; dst = '0; len = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, err, bus.mem_chipselect, bus.mem_write, bus.mem_address,
           bus.mem_byteenable, bus.mem_writedata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b err=%b cs=%b wr=%b addr=%0d be=%h wd=%h, required all 0",
                  busy, done, err, bus.mem_chipselect, bus.mem_write, bus.mem_address,
                  bus.mem_byteenable, bus.mem_writedata);
      end
      n_checks++;
      if (bus.mem_clken !== 1'b1) begin
         n_fail++; $display("FAIL reset_clken: got %b required 1", bus.mem_clken);
      end
      pause = 1'b1; #1;
      n_checks++;
      if (bus.mem_clken !== 1'b0) begin
         n_fail++; $display("FAIL reset_clken_pause: got %b required 0", bus.mem_clken);
      end
      pause = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic check_region(input string name, input int d, input int l);
      for (int i = 0; i < l; i++) begin
         n_checks++;
         if (ram[d+i] !== mdl[d+i]) begin
            n_fail++;
            $display("FAIL %s_ram[%0d]: got %h required %h", name, d+i, ram[d+i], mdl[d+i]);
         end
      end
   endtask

   task automatic test_basic_copy;
      int dc, cs, bc, cl; logic e;
      for (int i = 0; i < 4; i++) preload(100 + i, 32'hA0A0_0000 + i);
      model_copy(100, 200, 4);
      run_copy(100, 200, 4, 0, 0, 0, dc, e, cs, bc, cl);
      n_checks++;
      if (dc !== 13) begin n_fail++; $display("FAIL t1_done_cycle: got %0d required 13", dc); end
      n_checks++;
      if (e !== 1'b0) begin n_fail++; $display("FAIL t1_err: got %b required 0", e); end
      n_checks++;
      if (bc !== 12) begin n_fail++; $display("FAIL t1_busy_cycles: got %0d required 12", bc); end
      check_region("t1", 199, 6);
   endtask

   task automatic test_len_zero;
      int dc, cs, bc, cl; logic e;
      run_copy(100, 200, 0, 0, 0, 0, dc, e, cs, bc, cl);
      n_checks++;
      if (dc !== 1 || e !== 1'b1) begin
         n_fail++; $display("FAIL t2_done_err: got cycle %0d err %b required cycle 1 err 1", dc, e);
      end
      n_checks++;
      if (cs !== 0 || bc !== 0) begin
         n_fail++; $display("FAIL t2_no_bus: got cs=%0d busy=%0d required 0/0", cs, bc);
      end
   endtask

   task automatic test_range;
      int s_t[4] = '{11998, 100, 16383, 11997};
      int d_t[4] = '{500, 11998, 100, 500};
      int dc, cs, bc, cl, s, d; logic e; bit rej;
      for (int k = 0; k < 4; k++) begin
         s = s_t[k]; d = d_t[k];
         rej = expect_reject(s, d, 3);
         if (!rej) model_copy(s, d, 3);
         run_copy(s, d, 3, 0, 0, 0, dc, e, cs, bc, cl);
         n_checks++;
         if (e !== rej || dc !== (rej ? 1 : 10)) begin
            n_fail++;
            $display("FAIL t3_range_%0d: got err %b cycle %0d required err %b cycle %0d",
                     k, e, dc, rej, rej ? 1 : 10);
         end
         n_checks++;
         if (cs !== (rej ? 0 : 6)) begin
            n_fail++; $display("FAIL t3_cs_%0d: got %0d required %0d", k, cs, rej ? 0 : 6);
         end
      end
      n_checks++;
      if (last_rd !== 11999) begin
         n_fail++; $display("FAIL t3_last_read: got %0d required 11999", last_rd);
      end
      check_region("t3", 500, 3);
   endtask

   task automatic test_pause;
      int dc, cs, bc, cl; logic e;
      model_copy(1000, 2000, 4);
      run_copy(1000, 2000, 4, 5, 5, 0, dc, e, cs, bc, cl);
      n_checks++;
      if (dc !== 18) begin n_fail++; $display("FAIL t4_done_cycle: got %0d required 18", dc); end
      n_checks++;
      if (cl !== 5) begin n_fail++; $display("FAIL t4_clken_low: got %0d required 5", cl); end
      check_region("t4", 2000, 4);
   endtask

   task automatic test_reset_midcopy;
      int dc, cs, bc, cl, seen; logic e;
      @(posedge clk); #1;
      src = 14'd300; dst = 14'd400; len = 14'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (!(bus.mem_chipselect && bus.mem_write) || bus.mem_address !== 14'd401) begin
         n_fail++;
         $display("FAIL t5_in_wr1: got cs=%b wr=%b addr=%0d required 1/1/401",
                  bus.mem_chipselect, bus.mem_write, bus.mem_address);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done, err, bus.mem_chipselect, bus.mem_write, bus.mem_address,
           bus.mem_byteenable, bus.mem_writedata} !== '0) begin
         n_fail++;
         $display("FAIL t5_after_reset: busy=%b done=%b err=%b cs=%b wr=%b addr=%0d, required all 0",
                  busy, done, err, bus.mem_chipselect, bus.mem_write, bus.mem_address);
      end
      reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL t5_no_done: got %0d active cycles required 0", seen); end
      mdl[400] = mdl[300];
      mdl[401] = mdl[301];
      check_region("t5_partial", 400, 4);
      model_copy(300, 400, 4);
      run_copy(300, 400, 4, 0, 0, 0, dc, e, cs, bc, cl);
      n_checks++;
      if (dc !== 13 || e !== 1'b0) begin
         n_fail++; $display("FAIL t5_restart: got cycle %0d err %b required 13/0", dc, e);
      end
      check_region("t5", 400, 4);
   endtask

   task automatic test_overlap_and_ignore;
      int dc, cs, bc, cl, act; logic e;
      preload(10, 32'hDEAD_BEEF);
      for (int i = 11; i < 16; i++) preload(i, $urandom);
      @(posedge clk);
      model_copy(10, 11, 4);
      run_copy(10, 11, 4, 0, 0, 3, dc, e, cs, bc, cl);
      n_checks++;
      if (dc !== 13) begin n_fail++; $display("FAIL t6_done_cycle: got %0d required 13", dc); end
      act = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (busy || bus.mem_chipselect || done) act++;
      end
      n_checks++;
      if (act !== 0) begin n_fail++; $display("FAIL t6_start_ignored: got %0d active cycles required 0", act); end
      check_region("t6", 10, 6);
   endtask

   task automatic test_random;
      int s, d, l, pa, pl, base, dc, cs, bc, cl; logic e; bit rej;
      for (int k = 0; k < 12; k++) begin
         l = $urandom_range(1, 8);
         s = $urandom_range(0, DEPTH - l);
         if ($urandom_range(0, 1) == 1) d = s + $urandom_range(1, l);
         else d = $urandom_range(0, DEPTH - l);
         if ($urandom_range(0, 4) == 0) d = DEPTH - l + $urandom_range(0, 3);
         rej  = expect_reject(s, d, l);
         base = rej ? 1 : 1 + l * (2 + RL);
         pa = 0; pl = 0;
         if (!rej && $urandom_range(0, 1) == 1) begin
            pa = $urandom_range(1, base - 1);
            pl = $urandom_range(1, 3);
         end
         if (!rej) model_copy(s, d, l);
         run_copy(s, d, l, pa, pl, 0, dc, e, cs, bc, cl);
         n_checks++;
         if (dc !== base + pl || e !== rej) begin
            n_fail++;
            $display("FAIL rnd_%0d src=%0d dst=%0d len=%0d: got cycle %0d err %b required %0d/%b",
                     k, s, d, l, dc, e, base + pl, rej);
         end
         if (!rej) check_region("rnd", d, l);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; pause = 1'b0; src = '0; dst = '0; len = '0;
      for (int a = 0; a < NWORDS; a++) preload(a, $urandom);
      for (int i = 0; i < RL; i++) rd_pipe[i] <= '0;
      last_rd <= 0;
      test_reset();
      test_basic_copy();
      test_len_zero();
      test_range();
      test_pause();
      test_reset_midcopy();
      test_overlap_and_ignore();
      test_random();
      n_checks++;
      if (bad_bus !== 0) begin n_fail++; $display("FAIL bus_rules: got %0d violations required 0", bad_bus); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
